round_robin_arbiter: RTL and testbench

- Parametrised round-robin successor to the team's fixed-priority arbiter for NUM_PORTS requesters sharing one downstream channel.
- The grant is combinational from requests plus registered state, with zero latency.
- Priority rotates after every completed transfer.
- A stalled grant (valid without ready) is held stable until accepted. Optionally, multi-beat packets are locked to their owner until the last beat.

---
 rtl/rr_arb_pkg.sv | 29 ++
 rtl/rr_prio_pick.sv | 34 +++
 rtl/round_robin_arbiter.sv | 109 ++++++++++
 tb/tb_round_robin_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and helpers for the round-robin arbiter.
//   state_e       : arbiter FSM state (IDLE, HOLD)
//   next_idx      : increment an index modulo a port count
//   onehot_to_idx : binary index of the set bit of a one-hot vector
// Optional feature macro used by the arbiter: RR_ARB_LOCK_EN (packet lock).
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Upper bound on port count supported by onehot_to_idx.
  localparam int MAX_PORTS = 32;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // OR of the indices of set bits; exact for a one-hot or zero input.
  function automatic int onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < MAX_PORTS; i++)
      if (oh[i]) r = r | i;
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// rr_prio_pick: combinational round-robin pick.
//   req    in  NUM_PORTS  request vector
//   ptr    in  IDX_W      highest-priority port this cycle
//   onehot out NUM_PORTS  first requester at or after ptr (wrapping), or 0
//   idx    out IDX_W      binary index of onehot, 0 when none
// Rotates req so ptr sits at bit 0, isolates the lowest set bit, rotates back.
module rr_prio_pick
  import rr_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] onehot,
  output logic [IDX_W-1:0]     idx
);

  logic [2*NUM_PORTS-1:0] dbl;
  logic [2*NUM_PORTS-1:0] back;
  logic [NUM_PORTS-1:0]   rot;
  logic [NUM_PORTS-1:0]   first;

  always_comb begin
    dbl    = {req, req} >> ptr;
    rot    = dbl[NUM_PORTS-1:0];
    // Two's-complement trick keeps only the lowest set bit.
    first  = rot & (~rot + NUM_PORTS'(1));
    back   = {{NUM_PORTS{1'b0}}, first} << ptr;
    onehot = back[NUM_PORTS-1:0] | back[2*NUM_PORTS-1:NUM_PORTS];
    idx    = IDX_W'(onehot_to_idx(MAX_PORTS'(onehot)));
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: NUM_PORTS requesters sharing one downstream channel.
//   clk_i     in   clock
//   rst_i     in   synchronous active-high reset
//   req_i     in   per-port request (held until accepted)
//   last_i    in   per-port last-beat flag (only the granted port matters)
//   ready_i   in   downstream accepts the granted beat
//   gnt_o     out  one-hot grant or zero (combinational, zero latency)
//   gnt_idx_o out  binary index of grant, 0 when no grant
//   valid_o   out  |gnt_o
//   locked_o  out  arbiter is in HOLD
// Macro RR_ARB_LOCK_EN: when defined, a multi-beat packet keeps its owner
// until last_i; otherwise every transfer ends and HOLD only covers stalls.
module round_robin_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] last_i,
  input  logic                 ready_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 valid_o,
  output logic                 locked_o
);

  state_e               state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     owner_q;

  logic [NUM_PORTS-1:0] pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 ends;
  logic                 xfer;
  logic                 owner_req;

  rr_prio_pick #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req   (req_i),
    .ptr   (ptr_q),
    .onehot(pick_oh),
    .idx   (pick_idx)
  );

  assign owner_req = req_i[owner_q];

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    if (!rst_i) begin
      if (state_q == IDLE) begin
        gnt_o     = pick_oh;
        gnt_idx_o = pick_idx;
      end else if (owner_req) begin
        // Owner keeps the channel; late requesters are ignored.
        gnt_o[owner_q] = 1'b1;
        gnt_idx_o      = owner_q;
      end
    end
  end

  assign valid_o  = |gnt_o;
  assign locked_o = (state_q == HOLD) && !rst_i;
  assign xfer     = valid_o && ready_i;

`ifdef RR_ARB_LOCK_EN
  assign ends = |(last_i & gnt_o);
`else
  assign ends = 1'b1;
  logic unused_last;
  assign unused_last = ^last_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_o) begin
            if (xfer && ends) begin
              ptr_q <= IDX_W'(next_idx(int'(gnt_idx_o), NUM_PORTS));
            end else begin
              // Stall or mid-packet beat: pin the winner.
              state_q <= HOLD;
              owner_q <= gnt_idx_o;
            end
          end
        end
        HOLD: begin
          // Abandon and packet end both release and rotate past the owner.
          if (!owner_req || (xfer && ends)) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(next_idx(int'(owner_q), NUM_PORTS));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter (NUM_PORTS=4): directed steps
// from the test plan, then random traffic against a behavioural model.
module tb_round_robin_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  last;
  logic          ready;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          valid;
  logic          locked;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  int m_ptr   = 0;
  int m_owner = 0;
  bit m_hold  = 0;

  always #5 clk = ~clk;

  round_robin_arbiter #(.NUM_PORTS(N)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .last_i   (last),
    .ready_i  (ready),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .valid_o  (valid),
    .locked_o (locked)
  );

  // Winner per the rules: scan from ptr in IDLE, owner-only in HOLD; -1 = none.
  function automatic int model_winner();
    if (rst) return -1;
    if (m_hold) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic bit model_ends(input int g);
`ifdef RR_ARB_LOCK_EN
    return last[g];
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, check outputs against model (and optional literals),
  // clock once, advance model.
  task automatic step(input string tag, input logic r, input logic [N-1:0] rq,
                      input logic rdy, input logic [N-1:0] lst,
                      input bit lit, input logic [N-1:0] lg, input logic ll);
    int g;
    logic [N-1:0] eg;
    rst = r; req = rq; ready = rdy; last = lst;
    #1;
    g  = model_winner();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk({tag, ".gnt"},    int'(gnt),     int'(eg));
    chk({tag, ".idx"},    int'(gnt_idx), (g >= 0) ? g : 0);
    chk({tag, ".valid"},  int'(valid),   int'(g >= 0));
    chk({tag, ".locked"}, int'(locked),  int'(m_hold && !r));
    if (lit) begin
      chk({tag, ".gnt_lit"},    int'(gnt),    int'(lg));
      chk({tag, ".locked_lit"}, int'(locked), int'(ll));
    end
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_owner = 0; m_hold = 0;
    end else if (!m_hold) begin
      if (g >= 0) begin
        if (rdy && model_ends(g)) m_ptr = (g + 1) % N;
        else begin m_hold = 1; m_owner = g; end
      end
    end else if (!rq[m_owner] || (rdy && model_ends(m_owner))) begin
      m_hold = 0;
      m_ptr  = (m_owner + 1) % N;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = '0; last = '0; ready = 1'b0;
    @(negedge clk);
    // Reset: outputs forced low even with requests present.
    step("rst0", 1, 4'b1111, 1, 4'b1111, 1, 4'b0000, 0);
    step("rst1", 1, 4'b0000, 0, 4'b0000, 1, 4'b0000, 0);

    // Plan 1: rotation with all requesting.
    step("rot0", 0, 4'b1111, 1, 4'b1111, 1, 4'b0001, 0);
    step("rot1", 0, 4'b1111, 1, 4'b1111, 1, 4'b0010, 0);
    step("rot2", 0, 4'b1111, 1, 4'b1111, 1, 4'b0100, 0);
    step("rot3", 0, 4'b1111, 1, 4'b1111, 1, 4'b1000, 0);
    step("rot4", 0, 4'b1111, 1, 4'b1111, 1, 4'b0001, 0);

    // Plan 2: stall on port 1 (ptr=1), port 0 arrives mid-stall.
    step("stl0", 0, 4'b0110, 0, 4'b1111, 1, 4'b0010, 0);
    step("stl1", 0, 4'b0111, 0, 4'b1111, 1, 4'b0010, 1);
    step("stl2", 0, 4'b0111, 0, 4'b1111, 1, 4'b0010, 1);
    step("stl3", 0, 4'b0111, 1, 4'b1111, 1, 4'b0010, 1);
    step("stl4", 0, 4'b0101, 1, 4'b1111, 1, 4'b0100, 0);

    // Plan 4: stall on port 1 (ptr=3), then abandon.
    step("abn0", 0, 4'b0010, 0, 4'b1111, 1, 4'b0010, 0);
    step("abn1", 0, 4'b1101, 0, 4'b1111, 1, 4'b0000, 1);
    step("abn2", 0, 4'b1101, 0, 4'b1111, 1, 4'b0100, 0);

    // Plan 5: hold on port 3, reset pulse, then fresh arbitration.
    rst = 1'b1; @(posedge clk); @(negedge clk);
    m_ptr = 0; m_hold = 0; m_owner = 0;
    step("rmp0", 0, 4'b1000, 0, 4'b1111, 1, 4'b1000, 0);
    step("rmp1", 0, 4'b1000, 0, 4'b1111, 1, 4'b1000, 1);
    step("rmp2", 1, 4'b1000, 0, 4'b1111, 1, 4'b0000, 0);
    step("rmp3", 0, 4'b1111, 1, 4'b1111, 1, 4'b0001, 0);

`ifdef RR_ARB_LOCK_EN
    // Plan 3: get ptr=2, then port 2 owns a 3-beat packet.
    step("lck0", 0, 4'b0010, 1, 4'b0010, 1, 4'b0010, 0);
    step("lck1", 0, 4'b1111, 1, 4'b0000, 1, 4'b0100, 0);
    step("lck2", 0, 4'b1111, 1, 4'b0000, 1, 4'b0100, 1);
    step("lck3", 0, 4'b1111, 1, 4'b0100, 1, 4'b0100, 1);
    step("lck4", 0, 4'b1111, 1, 4'b1111, 1, 4'b1000, 0);
`else
    // Plan 6: last ignored, two ports alternate, never locked (ptr=1).
    step("nlk0", 0, 4'b0101, 1, 4'b0000, 1, 4'b0100, 0);
    step("nlk1", 0, 4'b0101, 1, 4'b0000, 1, 4'b0001, 0);
    step("nlk2", 0, 4'b0101, 1, 4'b0000, 1, 4'b0100, 0);
    step("nlk3", 0, 4'b0101, 1, 4'b0000, 1, 4'b0001, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 39) == 0), N'($urandom),
           ($urandom_range(0, 3) != 0), N'($urandom), 0, '0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
